// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
// Handshake and data bundle for the sequential divider.
//   start_valid / start_ready : operand pair handshake (requester -> divider)
//   Dividend, Divisor         : unsigned operands, WIDTH bits
//   out_valid / out_ready     : result handshake (divider -> consumer)
//   Quotient, Remainder       : unsigned results, WIDTH bits
//   DivByZero                 : captured divisor was zero
// Modports: master = requester/consumer side, slave = divider side.
// ----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;

    modport master (
        output start_valid, Dividend, Divisor, out_ready,
        input  start_ready, out_valid, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  start_valid, Dividend, Divisor, out_ready,
        output start_ready, out_valid, Quotient, Remainder, DivByZero
    );
endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (operand handshake, result handshake,
//           Quotient / Remainder / DivByZero outputs)
// An accepted nonzero-divisor operation produces its result WIDTH edges after
// acceptance; a zero divisor completes on the accepting edge with
// Quotient = all ones, Remainder = Dividend, DivByZero = 1.
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc holds the dividend; each step shifts its MSB out into the partial
    // remainder and shifts the new quotient bit in at the LSB.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] work_rem_q, work_rem_d;
    // Result registers are separate from the working registers so the
    // visible outputs only change when a finished result is loaded.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_acc;

    // One restoring step. Because the partial remainder is always below the
    // divisor, the shifted value fits in WIDTH+1 bits and the top bit of the
    // WIDTH+1-bit difference is exactly the borrow.
    always_comb begin
        shifted  = {work_rem_q, acc_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_q};
        borrow   = diff[WIDTH];
        step_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        step_acc = {acc_q[WIDTH-2:0], ~borrow};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        divisor_d  = divisor_q;
        work_rem_d = work_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    acc_d      = bus.Dividend;
                    divisor_d  = bus.Divisor;
                    work_rem_d = '0;
                    cnt_d      = '0;
                    if (bus.Divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.Dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d      = step_acc;
                work_rem_d = step_rem;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quot_d  = step_acc;
                    rem_d   = step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            divisor_q  <= '0;
            work_rem_q <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            divisor_q  <= divisor_d;
            work_rem_q <= work_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign bus.start_ready = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.Quotient    = quot_q;
    assign bus.Remainder   = rem_q;
    assign bus.DivByZero   = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider (WIDTH = 32).
// ----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;
    int   extra;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present an operand pair for one edge, then scramble the inputs so a
    // design that failed to register them would produce a wrong result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Dividend    = a;
        bus.Divisor     = b;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.Dividend    = ~a;
        bus.Divisor     = b + 32'd3;
    endtask

    // Count edges after acceptance until out_valid is seen, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.Dividend    = '0;
        bus.Divisor     = '0;

        // Reset state
        #2;
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst_quotient",    bus.Quotient,         32'd0);
        chk("rst_remainder",   bus.Remainder,        32'd0);
        chk("rst_divbyzero",   32'(bus.DivByZero),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 100 / 7, accepted on first edge after reset release
        start_op(32'd100, 32'd7);
        chk("busy_start_ready", 32'(bus.start_ready), 32'd0);
        chk("busy_out_valid",   32'(bus.out_valid),   32'd0);
        wait_valid(lat);
        chk("lat_100_7",  32'(lat),       32'd32);
        chk("q_100_7",    bus.Quotient,   32'd14);
        chk("r_100_7",    bus.Remainder,  32'd2);
        chk("dbz_100_7",  32'(bus.DivByZero), 32'd0);
        ack();
        chk("ack_out_valid",   32'(bus.out_valid),   32'd0);
        chk("ack_start_ready", 32'(bus.start_ready), 32'd1);
        chk("ack_q_held",      bus.Quotient,         32'd14);
        chk("ack_r_held",      bus.Remainder,        32'd2);

        // All-ones / 1
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_valid(lat);
        chk("lat_ff_1", 32'(lat),      32'd32);
        chk("q_ff_1",   bus.Quotient,  32'hFFFF_FFFF);
        chk("r_ff_1",   bus.Remainder, 32'd0);
        ack();

        // MSB-only / MSB-only
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_valid(lat);
        chk("q_msb_msb", bus.Quotient,  32'd1);
        chk("r_msb_msb", bus.Remainder, 32'd0);
        ack();

        // 5 / 0: result ready right after the accepting edge
        start_op(32'd5, 32'd0);
        chk("dbz_valid_on_accept_edge", 32'(bus.out_valid), 32'd1);
        chk("q_5_0",   bus.Quotient,  32'hFFFF_FFFF);
        chk("r_5_0",   bus.Remainder, 32'd5);
        chk("dbz_5_0", 32'(bus.DivByZero), 32'd1);
        ack();
        chk("dbz_held_after_ack", 32'(bus.DivByZero), 32'd1);

        // Reset pulse during BUSY iteration 10
        start_op(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("midrst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("midrst_quotient",    bus.Quotient,         32'd0);
        chk("midrst_remainder",   bus.Remainder,        32'd0);
        chk("midrst_divbyzero",   32'(bus.DivByZero),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        chk("no_valid_after_rst", 32'(extra), 32'd0);
        start_op(32'd1000, 32'd10);
        wait_valid(lat);
        chk("lat_1000_10", 32'(lat),      32'd32);
        chk("q_1000_10",   bus.Quotient,  32'd100);
        chk("r_1000_10",   bus.Remainder, 32'd0);
        ack();

        // 3 / 10 with the consumer stalling for 5 cycles
        start_op(32'd3, 32'd10);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_quotient",  bus.Quotient,       32'd0);
            chk("stall_remainder", bus.Remainder,      32'd3);
            @(posedge clk);
            #1;
        end
        chk("stall_still_valid", 32'(bus.out_valid), 32'd1);
        ack();
        chk("stall_idle_start_ready", 32'(bus.start_ready), 32'd1);
        chk("stall_idle_out_valid",   32'(bus.out_valid),   32'd0);

        // 100 / 7 with start_valid toggled and new operands during BUSY
        start_op(32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            bus.start_valid = i[0];
            bus.Dividend    = 32'd55 + 32'(i);
            bus.Divisor     = 32'd3;
            @(posedge clk);
            #1;
        end
        bus.start_valid = 1'b0;
        wait_valid(lat);
        chk("lat_toggle", 32'(lat + 10), 32'd32);
        chk("q_toggle",   bus.Quotient,  32'd14);
        chk("r_toggle",   bus.Remainder, 32'd2);
        chk("dbz_toggle", 32'(bus.DivByZero), 32'd0);
        ack();
        chk("end_start_ready", 32'(bus.start_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start_valid, input, 1, requester presents an operand pair.
REQ-006 The block SHALL have port start_ready, output, 1, block can accept an operand pair.
REQ-007 The block SHALL have port Dividend, input, WIDTH, unsigned dividend.
REQ-008 The block SHALL have port Divisor, input, WIDTH, unsigned divisor.
REQ-009 The block SHALL have port out_valid, output, 1, result is available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 The block SHALL have port Quotient, output, WIDTH, unsigned quotient.
REQ-012 The block SHALL have port Remainder, output, WIDTH, unsigned remainder.
REQ-013 The block SHALL have port DivByZero, output, 1, captured divisor was zero.

Function
REQ-014 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-015 start_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on a clock edge where start_valid and start_ready are both 1; Dividend and Divisor SHALL be registered on that edge.
REQ-017 On acceptance with nonzero Divisor, the next state SHALL be BUSY with the iteration counter at 0 and the partial remainder at 0.
REQ-018 Each BUSY cycle SHALL perform one restoring step:
- shift the partial remainder left by one, bringing in the next dividend MSB;
- compute the trial difference (partial remainder minus divisor) at WIDTH+1 bits;
- if there is no borrow, load the difference and shift quotient bit 1;
- otherwise, keep the shifted remainder and shift quotient bit 0.
REQ-019 On the edge ending BUSY iteration WIDTH-1, the block SHALL enter DONE, so out_valid rises exactly WIDTH edges after acceptance (32 for the default).
REQ-020 On acceptance with Divisor equal to 0, the next state SHALL be DONE with Quotient all ones, Remainder equal to Dividend and DivByZero 1 (latency: 1 edge).
REQ-021 DivByZero SHALL be 0 for every nonzero-divisor result.
REQ-022 In DONE, Quotient, Remainder and DivByZero SHALL hold stable until the edge where out_ready is 1; that edge SHALL move the state to IDLE.
REQ-023 The DONE-to-IDLE transition SHALL leave Quotient, Remainder and DivByZero unchanged until the next result is loaded.
REQ-024 Dividend, Divisor and start_valid SHALL be ignored in BUSY and DONE.
REQ-025 Input operand changes after acceptance SHALL NOT affect the result.
REQ-026 Back-to-back operations SHALL incur one IDLE cycle between out_ready acceptance and the next start acceptance.
REQ-027 For every nonzero divisor, the results SHALL satisfy Quotient*Divisor + Remainder = Dividend with Remainder < Divisor.
REQ-028 Outputs SHALL be driven from registers only, with no combinational path from inputs to outputs.

Reset
REQ-029 When rst_n is 0, the block SHALL immediately enter IDLE and clear the counter and internal registers, independent of clk.
REQ-030 Reset values SHALL be: start_ready=1, out_valid=0, Quotient=0, Remainder=0, DivByZero=0.
REQ-031 Reset asserted in BUSY or DONE SHALL discard the operation in progress; no out_valid pulse SHALL follow reset release.
REQ-032 The first acceptance SHALL be possible on the first clock edge after rst_n deasserts.

Verification
REQ-033 The bench SHALL cover: Dividend=100, Divisor=7 -> Quotient=14, Remainder=2, DivByZero=0, out_valid rises 32 edges after acceptance.
REQ-034 The bench SHALL cover: Dividend=0xFFFFFFFF, Divisor=1 -> Quotient=0xFFFFFFFF, Remainder=0; then Dividend=0x80000000, Divisor=0x80000000 -> Quotient=1, Remainder=0.
REQ-035 The bench SHALL cover: Dividend=5, Divisor=0 -> out_valid 1 edge after acceptance, Quotient=0xFFFFFFFF, Remainder=5, DivByZero=1.
REQ-036 The bench SHALL cover: Dividend=3, Divisor=10 with out_ready held 0 for 5 cycles -> Quotient=0, Remainder=3 stable and out_valid=1 throughout; IDLE after out_ready=1.
REQ-037 The bench SHALL cover: rst_n pulsed low at BUSY iteration 10 -> all outputs at reset values immediately, no out_valid afterward; a new 1000/10 then yields Quotient=100, Remainder=0.
REQ-038 The bench SHALL cover: start_valid toggled with new operands during BUSY -> ignored, and the original 100/7 result is unchanged.
